// File: rtl/noteseq_pkg.sv
// rtl/noteseq_pkg.sv - shared types, note-code fields and octave-8 pitch table for the note sequencer
package noteseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_APPLY = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int OCT_MSB  = 7;
    localparam int OCT_LSB  = 4;
    localparam int SEMI_MSB = 3;
    localparam int SEMI_LSB = 0;

    localparam logic [3:0] REST_MIN_SEMI = 4'd12;
    localparam logic [3:0] MAX_OCT       = 4'd8;
    localparam logic [7:0] TIE_CODE      = 8'hFF;

    // Equal-tempered octave 8, C8..B8, in millihertz (A8 = 7040 Hz)
    localparam logic [31:0] F8_MHZ [12] = '{
        32'd4186009, 32'd4434922, 32'd4698636, 32'd4978032,
        32'd5274041, 32'd5587652, 32'd5919911, 32'd6271927,
        32'd6644875, 32'd7040000, 32'd7458620, 32'd7902133
    };

    // round(mhz * 2^phase_width / (clk_hz * 1000))
    function automatic logic [63:0] mhz_to_fcw(input logic [31:0] mhz,
                                               input int          clk_hz,
                                               input int          phase_width);
        logic [127:0] num;
        logic [127:0] den;
        num = 128'(mhz) << phase_width;
        den = 128'(clk_hz) * 128'd1000;
        return 64'((num + (den >> 1)) / den);
    endfunction

endpackage

// File: rtl/noteseq_pattern_ram.sv
// rtl/noteseq_pattern_ram.sv - STEPS x 8 pattern store, one write port, one registered read port
module noteseq_pattern_ram #(
    parameter int STEPS = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(STEPS)-1:0] waddr,
    input  logic [7:0]               wdata,
    input  logic                     re,
    input  logic [$clog2(STEPS)-1:0] raddr,
    output logic [7:0]               rdata
);

    logic [7:0] mem [STEPS];

    // rdata holds between reads so a prefetched code is immune to later writes
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - pattern step sequencer feeding the DDS frequency word and gate; ties via NOTESEQ_TIE_EN
module note_sequencer
    import noteseq_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int STEPS       = 16,
    parameter int CLK_HZ      = 100_000_000
) (
    input  logic                     clk,
    input  logic                     rst_active_low,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [$clog2(STEPS)-1:0] last_step,
    input  logic [23:0]              step_period,
    input  logic [23:0]              gate_len,
    input  logic                     cfg_we,
    input  logic [$clog2(STEPS)-1:0] cfg_addr,
    input  logic [7:0]               cfg_data,
    output logic [PHASE_WIDTH-1:0]   freq_word,
    output logic                     gate,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int IW = $clog2(STEPS);

    state_e                 state;
    state_e                 state_next;
    logic [23:0]            per_q;
    logic [23:0]            glen_q;
    logic [23:0]            glen_act;
    logic [23:0]            cnt;
    logic [23:0]            cnt_inc;
    logic [23:0]            per_eff;
    logic [7:0]             rd_data;
    logic                   ram_re;
    logic [IW-1:0]          rd_addr;
    logic [IW-1:0]          next_idx;
    logic                   hold_term;
    logic                   fetch_entry;
    logic                   gate_fall;
    logic                   keep_gate;
    logic [3:0]             semi;
    logic [3:0]             oct_raw;
    logic [3:0]             oct;
    logic                   code_rest;
    logic [PHASE_WIDTH-1:0] fw_dec;
    logic [PHASE_WIDTH-1:0] note_fcw [16];

    generate
        for (genvar s = 0; s < 16; s++) begin : g_fcw
            if (s < 12) begin : g_note
                assign note_fcw[s] = PHASE_WIDTH'(mhz_to_fcw(F8_MHZ[s], CLK_HZ, PHASE_WIDTH));
            end else begin : g_rest
                assign note_fcw[s] = '0;
            end
        end
    endgenerate

    noteseq_pattern_ram #(.STEPS(STEPS)) u_ram (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .re    (ram_re),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        semi      = rd_data[SEMI_MSB:SEMI_LSB];
        oct_raw   = rd_data[OCT_MSB:OCT_LSB];
        oct       = (oct_raw > MAX_OCT) ? MAX_OCT : oct_raw;
        code_rest = (semi >= REST_MIN_SEMI);
        fw_dec    = note_fcw[semi] >> (MAX_OCT - oct);
    end

    assign per_eff   = (step_period < 24'd4) ? 24'd4 : step_period;
    assign cnt_inc   = cnt + 24'd1;
    assign next_idx  = (step_idx == last_step) ? '0 : step_idx + IW'(1);
    assign ram_re    = (state == ST_FETCH) || (state == ST_APPLY);
    assign rd_addr   = (state == ST_APPLY) ? next_idx : step_idx;
    // HOLD spans per-2 cycles; FETCH and APPLY complete the step
    assign hold_term = (state == ST_HOLD) && (cnt == per_q - 24'd3);
    assign busy      = (state != ST_IDLE);

`ifdef NOTESEQ_TIE_EN
    logic [7:0] next_code;
    logic       tie_step;
    logic       prev_rest;
    logic       first_step;
    logic       next_is_tie;

    // prefetched code is still on the RAM output during the first HOLD cycle
    assign next_is_tie = ((state == ST_HOLD) && (cnt == 24'd0)) ? (rd_data == TIE_CODE)
                                                                : (next_code == TIE_CODE);
    assign keep_gate   = tie_step || next_is_tie;
`else
    assign keep_gate   = 1'b0;
`endif

    assign gate_fall = (cnt_inc == glen_act) && !keep_gate;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_APPLY;
            ST_APPLY: state_next = ST_HOLD;
            ST_HOLD: begin
                if (hold_term) begin
                    if ((step_idx != last_step) || loop_en) state_next = ST_FETCH;
                    else                                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
        if (stop) state_next = ST_IDLE;
    end

    assign fetch_entry = (state_next == ST_FETCH) && (state != ST_FETCH);

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            freq_word  <= '0;
            gate       <= 1'b0;
            step_idx   <= '0;
            done       <= 1'b0;
            per_q      <= 24'd4;
            glen_q     <= 24'd0;
            glen_act   <= 24'd0;
            cnt        <= 24'd0;
`ifdef NOTESEQ_TIE_EN
            next_code  <= 8'd0;
            tie_step   <= 1'b0;
            prev_rest  <= 1'b0;
            first_step <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (fetch_entry) begin
                per_q  <= per_eff;
                glen_q <= gate_len;
            end
            if (stop) begin
                gate <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            step_idx   <= '0;
`ifdef NOTESEQ_TIE_EN
                            first_step <= 1'b1;
`endif
                        end
                    end
                    ST_FETCH: begin
                        cnt <= cnt_inc;
                        if (gate_fall) gate <= 1'b0;
                    end
                    ST_APPLY: begin
                        cnt      <= 24'd0;
                        glen_act <= glen_q;
`ifdef NOTESEQ_TIE_EN
                        first_step <= 1'b0;
                        if ((rd_data == TIE_CODE) && !prev_rest && !first_step) begin
                            tie_step <= 1'b1;
                        end else begin
                            tie_step  <= 1'b0;
                            prev_rest <= code_rest;
                            if (code_rest) begin
                                gate <= 1'b0;
                            end else begin
                                freq_word <= fw_dec;
                                gate      <= (glen_q != 24'd0);
                            end
                        end
`else
                        if (code_rest) begin
                            gate <= 1'b0;
                        end else begin
                            freq_word <= fw_dec;
                            gate      <= (glen_q != 24'd0);
                        end
`endif
                    end
                    ST_HOLD: begin
                        cnt <= cnt_inc;
                        if (gate_fall) gate <= 1'b0;
`ifdef NOTESEQ_TIE_EN
                        if (cnt == 24'd0) next_code <= rd_data;
`endif
                        if (hold_term) begin
                            if (step_idx != last_step) begin
                                step_idx <= step_idx + IW'(1);
                            end else if (loop_en) begin
                                step_idx <= '0;
                            end else begin
                                gate <= 1'b0;
                                done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst_active_low = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [3:0]  last_step = 4'd0;
    logic [23:0] step_period = 24'd0;
    logic [23:0] gate_len = 24'd0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic [7:0]  cfg_data = 8'd0;
    logic [31:0] freq_word;
    logic        gate;
    logic [3:0]  step_idx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] fw_l [512];
    logic        gt_l [512];
    logic        bs_l [512];
    logic        dn_l [512];
    logic [3:0]  ix_l [512];

    note_sequencer #(.PHASE_WIDTH(32), .STEPS(16), .CLK_HZ(100_000_000)) dut (
        .clk            (clk),
        .rst_active_low (rst_active_low),
        .start          (start),
        .stop           (stop),
        .loop_en        (loop_en),
        .last_step      (last_step),
        .step_period    (step_period),
        .gate_len       (gate_len),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .freq_word      (freq_word),
        .gate           (gate),
        .step_idx       (step_idx),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_pat(input logic [3:0] addr, input logic [7:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic setup(input logic [3:0] ls, input logic lp, input int per, input int gl);
        last_step   = ls;
        loop_en     = lp;
        step_period = 24'(per);
        gate_len    = 24'(gl);
    endtask

    // cycle 0 is the cycle in which start is presented; stop_at < 0 means no stop
    task automatic run(input int n, input int stop_at);
        for (int c = 0; c < n; c++) begin
            fw_l[c] = freq_word;
            gt_l[c] = gate;
            bs_l[c] = busy;
            dn_l[c] = done;
            ix_l[c] = step_idx;
            start   = (c == 0);
            stop    = (c == stop_at);
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    function automatic int count(input int sel, input int lo, input int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) begin
            case (sel)
                0:       s += int'(gt_l[c]);
                1:       s += int'(dn_l[c]);
                default: s += int'(bs_l[c]);
            endcase
        end
        return s;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_freq", freq_word, 0);
        check("rst_gate", gate, 0);
        check("rst_idx", step_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_active_low = 1'b1;
        @(negedge clk);

        // two-step pattern, A4 then C8
        write_pat(4'd0, 8'h49);
        write_pat(4'd1, 8'h80);
        setup(4'd1, 1'b0, 100, 60);
        run(210, -1);
        check("t1_fw_c2", fw_l[2], 0);
        check("t1_fw_c3", fw_l[3], 18897);
        check("t1_gate_c3", gt_l[3], 1);
        check("t1_idx_c3", ix_l[3], 0);
        check("t1_busy_c1", bs_l[1], 1);
        check("t1_gate_c62", gt_l[62], 1);
        check("t1_gate_c63", gt_l[63], 0);
        check("t1_fw_c102", fw_l[102], 18897);
        check("t1_fw_c103", fw_l[103], 179788);
        check("t1_idx_c103", ix_l[103], 1);
        check("t1_gate_total", count(0, 0, 209), 120);
        check("t1_busy_c200", bs_l[200], 1);
        check("t1_done_c201", dn_l[201], 1);
        check("t1_busy_c201", bs_l[201], 0);
        check("t1_done_total", count(1, 0, 209), 1);

        // rest on step 1
        write_pat(4'd1, 8'h4C);
        run(210, -1);
        check("t2_gate_c103", gt_l[103], 0);
        check("t2_fw_c150", fw_l[150], 18897);
        check("t2_gate_total", count(0, 0, 209), 60);
        check("t2_done_c201", dn_l[201], 1);

        // looping three steps, stopped in HOLD of the second pass's step 1
        write_pat(4'd1, 8'h80);
        write_pat(4'd2, 8'h40);
        setup(4'd2, 1'b1, 100, 60);
        run(460, 450);
        check("t3_idx_c3", ix_l[3], 0);
        check("t3_idx_c103", ix_l[103], 1);
        check("t3_idx_c203", ix_l[203], 2);
        check("t3_idx_c303", ix_l[303], 0);
        check("t3_idx_c403", ix_l[403], 1);
        check("t3_fw_c203", fw_l[203], 11236);
        check("t3_gate_total", count(0, 0, 449), 287);
        check("t3_done_total", count(1, 0, 459), 0);
        check("t3_gate_c450", gt_l[450], 1);
        check("t3_gate_c451", gt_l[451], 0);
        check("t3_busy_c451", bs_l[451], 0);
        check("t3_fw_c451", fw_l[451], 179788);

        // minimum step length with gate covering the whole step
        setup(4'd1, 1'b0, 1, 100);
        run(16, -1);
        check("t4_fw_c3", fw_l[3], 18897);
        check("t4_gate_c6", gt_l[6], 1);
        check("t4_fw_c7", fw_l[7], 179788);
        check("t4_idx_c7", ix_l[7], 1);
        check("t4_gate_total", count(0, 0, 15), 6);
        check("t4_done_c9", dn_l[9], 1);
        check("t4_busy_c9", bs_l[9], 0);

        // start and stop together
        run(8, 0);
        check("t5_busy_total", count(2, 0, 7), 0);
        check("t5_fw_c7", fw_l[7], 179788);

        // 0xFF on step 1
        write_pat(4'd1, 8'hFF);
        setup(4'd2, 1'b0, 100, 60);
        run(310, -1);
        check("t6_fw_c150", fw_l[150], 18897);
        check("t6_fw_c203", fw_l[203], 11236);
        check("t6_done_c301", dn_l[301], 1);
`ifdef NOTESEQ_TIE_EN
        check("t6_gate_c150", gt_l[150], 1);
        check("t6_gate_c263", gt_l[263], 0);
        check("t6_gate_total", count(0, 0, 309), 260);
`else
        check("t6_gate_c150", gt_l[150], 0);
        check("t6_gate_c203", gt_l[203], 1);
        check("t6_gate_total", count(0, 0, 309), 120);
`endif

        // asynchronous reset in HOLD of step 1
        write_pat(4'd1, 8'h80);
        setup(4'd1, 1'b0, 100, 60);
        run(150, -1);
        rst_active_low = 1'b0;
        #1;
        check("t7_rst_freq", freq_word, 0);
        check("t7_rst_gate", gate, 0);
        check("t7_rst_idx", step_idx, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_done", done, 0);
        @(negedge clk);
        rst_active_low = 1'b1;
        @(negedge clk);
        write_pat(4'd0, 8'h49);
        write_pat(4'd1, 8'h80);
        run(10, -1);
        check("t7_fw_c3", fw_l[3], 18897);
        check("t7_idx_c3", ix_l[3], 0);
        check("t7_gate_c3", gt_l[3], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Step sequencer that drives the DDS sine voice. It holds a programmable pattern of up to STEPS note codes and walks through it at a programmable step rate. For each step it converts the note code to a phase-increment word for the DDS and produces a gate for downstream envelope/mute logic. It sits between the control/config bus and the DDS sine block's frequency input.

## Interface
- PHASE_WIDTH, 32: width of the frequency control word; must match the DDS.
- STEPS, 16: pattern depth; power of two, 2..256.
- CLK_HZ, 100_000_000: system clock frequency, used at elaboration to build the note table.

- clk  in  1  system clock, rising edge.
- rst_active_low  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  pulse; begin playback at step 0 (honoured only in IDLE).
- stop  in  1  pulse; abort playback.
- loop_en  in  1  restart at step 0 after last_step instead of stopping.
- last_step  in  $clog2(STEPS)  index of final step in pattern.
- step_period  in  24  clocks per step; values below 4 are treated as 4.
- gate_len  in  24  clocks gate stays high within a step; 0 means never high; values at or above step_period mean the whole step.
- cfg_we  in  1  pattern write strobe.
- cfg_addr  in  $clog2(STEPS)  pattern write address.
- cfg_data  in  8  note code: [7:4] octave, [3:0] semitone.
- freq_word  out  PHASE_WIDTH  DDS frequency control word (registered).
- gate  out  1  note-on (registered).
- step_idx  out  $clog2(STEPS)  step currently sounding.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when non-looping playback ends.

## Operation
- Note code decoding:
  - Semitone 0..11 is C..B.
  - Semitone 12..15 is a rest: gate stays low for the step and freq_word holds its previous value.
  - Octave 9..15 clamps to 8.
- Frequency word: freq_word = NOTE_FCW[semi] >> (8 − oct).
  - NOTE_FCW[s] = round(f8[s]·2^PHASE_WIDTH / CLK_HZ), where f8 is the equal-tempered octave-8 frequency (A8 = 7040 Hz).
  - The table is computed at elaboration. The shift truncates.
- FSM states: IDLE, FETCH, APPLY, HOLD.
  - IDLE → FETCH on start; step_idx ← 0.
  - FETCH: pattern read address = step_idx; the synchronous read returns data the next cycle.
  - APPLY: decode and register freq_word and gate. Issue a read of the next index (step_idx+1, or 0 after last_step) and latch it into next_code on HOLD entry.
  - HOLD: the step counter runs. At the terminal count:
    - step_idx ≠ last_step: step_idx increments, go to FETCH.
    - step_idx = last_step and loop_en: step_idx ← 0, go to FETCH.
    - otherwise: go to IDLE, pulse done, drive gate low.
- Gate falls when the step counter reaches gate_len (tie exception below).
- stop has priority from any state: IDLE next cycle, gate low, freq_word held, no done pulse.
  - start and stop in the same cycle: stop wins.
  - start while busy is ignored.
- Pattern writes are accepted in any state. A write to a step takes effect the next time that step is fetched. A write to the already-prefetched next step is not seen until its following fetch.
- last_step and loop_en are sampled at the HOLD terminal count. step_period and gate_len are sampled on FETCH entry.

## Timing
- Reset values: freq_word 0, gate 0, step_idx 0, busy 0, done 0; FSM in IDLE; pattern RAM contents undefined.
- start sampled at cycle 0 → FETCH at cycle 1, APPLY at cycle 2 → freq_word and gate valid at cycle 3.
- Step length is exactly max(step_period, 4) clocks from one freq_word update to the next (FETCH and APPLY are included).
- Gate is high for min(gate_len, step length) clocks, counted from the cycle freq_word updates.
- done coincides with the first IDLE cycle; busy falls in the same cycle.

## Configuration
- NOTESEQ_TIE_EN defined:
  - Code 8'hFF is a tie: freq_word and gate are unchanged for the whole step.
  - When next_code is a tie, the current step's gate does not fall at gate_len.
  - A tie directly after a rest, or at step 0 after start, behaves as a rest.
- NOTESEQ_TIE_EN undefined: 8'hFF is an ordinary rest. next_code is still fetched but unused.

## Structure
- Package noteseq_pkg holds:
  - the state enum;
  - field positions, REST_MIN_SEMI = 12 and TIE_CODE = 8'hFF;
  - the f8 semitone table in millihertz;
  - a constant function that turns mHz into an FCW from CLK_HZ and PHASE_WIDTH.
- Sub-module noteseq_pattern_ram: STEPS×8, one write port, one synchronous read port, no reset.

## Test plan
- Pattern [0x49, 0x80], last_step=1, loop_en=0, step_period=100, gate_len=60, start → two steps:
  - step 0: freq_word 18897 (A4) with gate high 60 clocks;
  - step 1: freq_word 179788 (C8) with gate high 60 clocks;
  - then done pulse at cycle 201 with busy low.
- Step 1 = 0x4C (rest) → gate low for 100 clocks while freq_word stays 18897.
- loop_en=1, last_step=2 → step_idx sequence 0,1,2,0,1; done never pulses; stop mid-HOLD → gate low next cycle, busy low, freq_word held.
- step_period=1, gate_len=100 → 4-clock steps with gate high for the whole step; start+stop same cycle → stays IDLE.
- With NOTESEQ_TIE_EN, pattern [0x49, 0xFF, 0x40] → gate high continuously across steps 0–1 with freq_word 18897, then step 2 updates freq_word. Without the macro, step 1 is a rest.
- Assert rst_active_low mid-HOLD → all outputs return to reset values immediately (asynchronously); the first start after release plays from step 0.
